// File: rtl/prio2bin_seq.sv
// prio2bin_seq: sequential priority decoder.
// Takes a DW-bit request vector over a valid/ready handshake. It then emits
// the binary index of every set bit, highest index first, one index per
// output handshake. An all-zero vector yields a single beat flagged out_zero.
module prio2bin_seq #(
  parameter int DW = 32,
  localparam int AW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          out_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [DW-1:0] pend;      // indices still to be emitted
  logic          zero;      // accepted vector was all-zero
  logic [DW-1:0] top_bit;   // one-hot mask of the highest pending bit
  logic [AW-1:0] top_idx;   // binary index of the highest pending bit
  logic          single;    // pend holds exactly one set bit

  // Priority decode of the registered pending vector. The last match in
  // ascending order wins, so the result is the highest set bit.
  always_comb begin
    top_idx = '0;
    top_bit = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (pend[i]) begin
        top_idx    = AW'(i);
        top_bit    = '0;
        top_bit[i] = 1'b1;
      end
    end
    single = (pend != '0) && ((pend & (pend - DW'(1))) == '0);
  end

  // Output beat fields come only from registered state. An empty pend
  // decodes to index 0. That value serves both the reset value and the
  // single beat of a zero vector.
  always_comb begin
    out_idx  = top_idx;
    out_last = zero | single;
    out_zero = zero;
  end

  // Handshake FSM: load the vector on accept, then peel off one bit per
  // output handshake until the last beat returns the block to IDLE.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= IDLE;
      pend      <= '0;
      zero      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            pend      <= in_data;
            zero      <= (in_data == '0);
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              pend      <= '0;
              zero      <= 1'b0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              pend <= pend & ~top_bit;
            end
          end
        end
        default: begin
          state     <= IDLE;
          pend      <= '0;
          zero      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/prio2bin_seq.md
# prio2bin_seq

Sequential priority decoder: accepts a DW-bit request vector over a valid/ready handshake and emits the binary index of every set bit, one index per output handshake, highest index first. It is the consumer-side counterpart of the combinational priority encoder. Where the encoder flags only the top set bit, this block walks the whole vector and serialises it into a stream of indices. It sits between a request collector (interrupt pending register, dirty-line mask, grant vector) and a downstream engine that services one index at a time.

## Interface
- DW, default 32, input vector width; legal values 2..1024.
- AW, local, $clog2(DW), index width; not overridable.

- clk  input  1  clock; all state changes on the rising edge.
- nreset  input  1  reset; synchronous, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a vector; registered.
- in_data  input  DW  request vector; bit i set means index i is pending.
- out_valid  output  1  out_idx / out_last / out_zero are valid; registered.
- out_ready  input  1  downstream accepts the current beat.
- out_idx  output  AW  binary index of the highest remaining set bit.
- out_last  output  1  current beat is the final beat of the vector.
- out_zero  output  1  accepted vector was all-zero; the beat carries no index.

## Operation
- State: a two-state FSM (IDLE, BUSY) and a DW-bit register pend.
- Reset (nreset=0 at a clk edge):
  - state=IDLE, pend=0.
  - in_ready=0 and out_valid=0.
  - out_idx, out_last and out_zero read 0.
  - in_ready goes to 1 on the first edge with nreset=1.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: pend<=in_data, zero flag<=(in_data==0), in_ready<=0, out_valid<=1, state<=BUSY.
- BUSY:
  - out_idx = the highest i with pend[i]=1.
  - out_last = 1 when pend has exactly one set bit.
  - out_zero=0 while pend!=0.
  - On out_valid && out_ready with out_last=0: clear pend[out_idx] and stay in BUSY. out_valid remains 1.
  - On out_valid && out_ready with out_last=1: pend<=0, out_valid<=0, in_ready<=1, state<=IDLE.
- All-zero vector:
  - Produces exactly one beat with out_zero=1, out_last=1, out_idx=0.
  - The handshake of that beat returns the block to IDLE.
- Output stability: while out_valid=1 and out_ready=0, out_idx, out_last and out_zero do not change.
- Input sampling: in_data is sampled only on the accept edge. Changes to in_data in BUSY are ignored. in_valid in BUSY is ignored, because in_ready=0 there.
- Backpressure: out_ready may toggle arbitrarily. The beat sequence is unaffected; only its timing changes.
- Beat count: a vector with k set bits yields exactly k beats (1 beat if k=0). Indices are strictly decreasing.
- Reset mid-operation: nreset=0 in BUSY discards pend with no further beats. The block resumes in IDLE with the post-reset values above.
- Index arithmetic:
  - out_idx is an unsigned AW-bit value.
  - For non-power-of-two DW, values >= DW never appear.
  - Bit DW-1 maps to index DW-1.

## Timing
- Accept-to-first-beat latency: 1 cycle. Accept on edge T; out_valid=1 during cycle T+1.
- Throughput: one index per cycle while out_ready=1.
- Vector turnaround: the final beat handshakes on edge E, and in_ready=1 during cycle E+1. The next vector can then be accepted on edge E+1.
- Minimum period between accepts is k+1 cycles for k set bits (2 cycles for a zero vector).
- No combinational path from in_valid/in_data to any output, or from out_ready to in_ready.
- out_idx/out_last are decoded from registered pend. The priority-decode depth is the critical path, and it is the only combinational cone driving the outputs.

## Test plan
- Reset then single vector (DW=8):
  - Hold nreset=0 for 3 cycles; in_ready=0 and out_valid=0 throughout. in_ready=1 one edge after release.
  - Send 0xA5 with out_ready=1. Expect out_idx 7,5,2,0 on 4 consecutive cycles, out_last=1 only on idx 0, out_zero=0.
  - in_ready=1 the cycle after the last beat.
- Zero vector: send 0x00 -> one beat with out_zero=1, out_last=1, out_idx=0, then back to IDLE. Send 0x80 -> one beat idx=7, out_last=1, out_zero=0.
- Backpressure:
  - Send 0x81 with out_ready low for 5 cycles: out_valid=1 and out_idx=7 hold steady.
  - Raise out_ready for one cycle, then low 2 cycles, then high: idx 0 appears with out_last=1.
  - in_valid/in_data toggled during BUSY have no effect.
- Full vector, DW=32: send 0xFFFFFFFF with out_ready=1 -> 32 beats, idx 31 down to 0, last on 0. Next accept no earlier than 33 cycles after the first.
- Reset mid-stream: send 0xF0, take 2 beats (7,6), then assert nreset for 1 cycle. Expect out_valid=0 and no beats for idx 5/4. A new vector 0x02 yields a single beat idx=1, out_last=1.
- Randomized-backpressure regression:
  - Random vectors, DW in {8, 13, 32}, random in_valid/out_ready.
  - A scoreboard checks beat count = popcount (or 1 for zero), strictly decreasing indices, exactly one out_last per vector, and no index >= DW.
